dp_ram_stream_rd: RTL and testbench

Read-side sequencer for a dual-port block RAM with 1-cycle registered read latency. On a start command it issues sequential reads from a base address for a given word count, wrapping circularly at DEPTH. It presents the words as a valid/ready stream with a last marker, so downstream consumers drain buffers filled by an independent write side. A 2-entry skid absorbs read latency, giving 1 word/cycle under continuous ready with no data loss on backpressure.

---
 rtl/dp_ram_pkg.sv | 15 +
 rtl/rd_skid.sv | 57 +++++
 rtl/dp_ram_stream_rd.sv | 120 ++++++++++++
 tb/tb_dp_ram_stream_rd.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared FSM type and address helper for the RAM stream reader
package dp_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Next read address with circular wrap; depth need not be a power of two.
    function automatic int unsigned addr_inc(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/rd_skid.sv
// rtl/rd_skid.sv - two-entry skid FIFO absorbing the RAM read latency
module rd_skid #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] slot0;
    logic [DW-1:0] slot1;

    // slot0 is always the head; a pop shifts slot1 forward
    assign head = slot0;

    // storage and occupancy; flush wins over push and pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // the credit rule upstream must never let a net push land on a full skid
    assert property (@(posedge clk) disable iff (reset)
        (push && !pop && !flush) |-> (count != 2'd2));

endmodule

// File: rtl/dp_ram_stream_rd.sv
// rtl/dp_ram_stream_rd.sv - sequential circular RAM reader presented as a valid/ready stream
module dp_ram_stream_rd #(
    parameter  int DW    = 18,
    parameter  int DEPTH = 360,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    output logic          re,
    input  logic [DW-1:0] rd,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    import dp_ram_pkg::*;

    localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t      state;
    logic [AW:0] issue_rem;
    logic [AW:0] len_q;
    logic [AW:0] beat_cnt;
    logic        inflight;
    logic [1:0]  skid_count;
    logic        pop;
    logic        flush;
    logic [2:0]  credit_use;

    assign pop       = out_valid & out_ready;
    assign flush     = abort && (state != IDLE);
    assign out_valid = (skid_count != 2'd0);
    assign out_last  = out_valid && (beat_cnt == len_q - ONE_W);

    // words held or on their way after this cycle's pop; a new read needs room for one more
    assign credit_use = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    assign re = (state == RUN) && !abort && (issue_rem != '0) && (credit_use < 3'd2);

    rd_skid #(.DW(DW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (rd),
        .pop       (pop),
        .flush     (flush),
        .head      (out_data),
        .count     (skid_count)
    );

    // transfer sequencer: command capture, read issue, drain and completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ra        <= '0;
            inflight  <= 1'b0;
            issue_rem <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= re;
            if (flush) begin
                // a read returning after abort must not reach the skid
                state     <= IDLE;
                busy      <= 1'b0;
                inflight  <= 1'b0;
                issue_rem <= '0;
            end else begin
                if (pop) beat_cnt <= beat_cnt + ONE_W;
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (len != '0) begin
                                state     <= RUN;
                                busy      <= 1'b1;
                                ra        <= base_addr;
                                issue_rem <= len;
                                len_q     <= len;
                                beat_cnt  <= '0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (re) begin
                            ra        <= AW'(addr_inc(32'(ra), DEPTH));
                            issue_rem <= issue_rem - ONE_W;
                            if (issue_rem == ONE_W) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && out_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // the caller must keep the base address inside the RAM
    assert property (@(posedge clk) disable iff (reset)
        (state == IDLE && start && len != '0) |-> ({1'b0, base_addr} < DEPTH_W));

endmodule

// File: tb/tb_dp_ram_stream_rd.sv
// tb/tb_dp_ram_stream_rd.sv - directed self-checking bench for dp_ram_stream_rd
module tb_dp_ram_stream_rd;

    localparam int DW    = 18;
    localparam int DEPTH = 360;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] ra;
    logic          re;
    logic [DW-1:0] rd;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] mem [0:DEPTH-1];

    int total = 0;
    int bad   = 0;

    dp_ram_stream_rd #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ra        (ra),
        .re        (re),
        .rd        (rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rd <= mem[ra];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // start a transfer with out_ready high and check every cycle up to the done pulse;
    // when inj > 0 a conflicting start is pulsed at that cycle and must be ignored
    task automatic xfer(input int b, input int n, input int inj, input string tag);
        int reads;
        reads = 0;
        nx();
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(n);
        #1;
        for (int c = 1; c <= n + 4; c++) begin
            nx();
            start = (c == inj);
            if (c == inj) begin
                base_addr = 9'd200;
                len       = 10'd5;
            end
            #1;
            if (re) begin
                chk({tag, "_ra"}, 32'(ra), 32'((b + reads) % DEPTH));
                reads++;
            end
            if (c == 1) begin
                chk({tag, "_busy1"}, 32'(busy), 1);
                chk({tag, "_re1"}, 32'(re), 1);
            end
            if (c >= 3 && c <= n + 2) begin
                chk({tag, "_valid"}, 32'(out_valid), 1);
                chk({tag, "_data"}, 32'(out_data), 32'((b + c - 3) % DEPTH));
                chk({tag, "_last"}, 32'(out_last), 32'(c == n + 2));
                chk({tag, "_nodone"}, 32'(done), 0);
            end
            if (c == n + 3) begin
                chk({tag, "_done"}, 32'(done), 1);
                chk({tag, "_busy_end"}, 32'(busy), 0);
                chk({tag, "_valid_end"}, 32'(out_valid), 0);
            end
            if (c == n + 4) chk({tag, "_done_clr"}, 32'(done), 0);
        end
        chk({tag, "_nreads"}, 32'(reads), 32'(n));
    endtask

    initial begin
        logic [5:0]    rpat;
        logic [DW-1:0] prev_data;
        logic          stalled_prev;
        int            issued;
        int            got;
        logic          fin;

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        rd = '0;
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; abort = 1'b0; out_ready = 1'b1;

        // reset state
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_re", 32'(re), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ra", 32'(ra), 0);
        chk("rst_last", 32'(out_last), 0);
        nx();
        reset = 1'b0;

        // basic transfer and wrap across DEPTH-1 -> 0
        xfer(10, 4, 0, "a");
        xfer(358, 5, 0, "b");

        // backpressure with ready pattern 1,0,0,1,0,1
        rpat = 6'b101001;
        nx();
        start = 1'b1; base_addr = 9'd100; len = 10'd6;
        #1;
        issued = 0; got = 0; fin = 1'b0; stalled_prev = 1'b0; prev_data = '0;
        for (int c = 0; c < 60 && !fin; c++) begin
            nx();
            start = 1'b0;
            out_ready = rpat[c % 6];
            #1;
            if (re) issued++;
            if (stalled_prev) begin
                chk("c_hold_valid", 32'(out_valid), 1);
                chk("c_hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                chk("c_data", 32'(out_data), 32'(100 + got));
                chk("c_last", 32'(out_last), 32'(got == 5));
                got++;
            end
            chk("c_credit", 32'((issued - got) <= 2), 1);
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            if (done) fin = 1'b1;
        end
        chk("c_beats", 32'(got), 6);
        chk("c_reads", 32'(issued), 6);
        chk("c_done_seen", 32'(fin), 1);
        out_ready = 1'b1;

        // abort at the third beat handshake
        nx();
        start = 1'b1; base_addr = 9'd20; len = 10'd8;
        #1;
        nx(); start = 1'b0; #1;
        nx(); #1;
        nx(); #1;
        chk("d_beat0", 32'(out_data), 20);
        nx(); #1;
        chk("d_beat1", 32'(out_data), 21);
        nx(); abort = 1'b1; #1;
        chk("d_beat2_valid", 32'(out_valid), 1);
        chk("d_beat2", 32'(out_data), 22);
        nx(); abort = 1'b0; #1;
        chk("d_busy", 32'(busy), 0);
        chk("d_valid", 32'(out_valid), 0);
        chk("d_re", 32'(re), 0);
        chk("d_done", 32'(done), 0);
        nx(); #1;
        chk("d_valid2", 32'(out_valid), 0);
        chk("d_re2", 32'(re), 0);
        chk("d_done2", 32'(done), 0);
        xfer(0, 2, 0, "d2");

        // zero-length start
        nx();
        start = 1'b1; base_addr = 9'd7; len = 10'd0;
        #1;
        nx(); start = 1'b0; #1;
        chk("e_done", 32'(done), 1);
        chk("e_busy", 32'(busy), 0);
        chk("e_re", 32'(re), 0);
        chk("e_valid", 32'(out_valid), 0);
        nx(); #1;
        chk("e_done_clr", 32'(done), 0);
        chk("e_re2", 32'(re), 0);
        chk("e_valid2", 32'(out_valid), 0);

        // start while busy is ignored
        xfer(50, 3, 2, "e2");

        // asynchronous reset mid-transfer
        nx();
        start = 1'b1; base_addr = 9'd30; len = 10'd10;
        #1;
        nx(); start = 1'b0; #1;
        nx(); #1;
        nx(); #1;
        chk("f_pre_valid", 32'(out_valid), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("f_busy", 32'(busy), 0);
        chk("f_re", 32'(re), 0);
        chk("f_valid", 32'(out_valid), 0);
        chk("f_ra", 32'(ra), 0);
        chk("f_last", 32'(out_last), 0);
        chk("f_done", 32'(done), 0);
        nx();
        reset = 1'b0;
        #1;
        chk("f_post_valid", 32'(out_valid), 0);
        xfer(5, 1, 0, "f2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
